// File: rtl/music_pkg.sv
// music_pkg: constants shared by the music player, its tone divider and the score RAM.
package music_pkg;
    localparam int KEY_W  = 4;
    localparam int TIME_W = 4;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    // Tone half-periods in clock cycles, indexed by key; key 0 is a rest.
    localparam int HALF_PERIOD [16] = '{0, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19};

    function automatic int max_half_period();
        int m = 0;
        foreach (HALF_PERIOD[i]) m = (HALF_PERIOD[i] > m) ? HALF_PERIOD[i] : m;
        return m;
    endfunction

    localparam int TONE_W = $clog2(max_half_period() + 1);
endpackage

// File: rtl/tone_divider.sv
// tone_divider: square-wave generator whose half-period is looked up from the key.
module tone_divider import music_pkg::*; #(
    parameter int KeyBits = KEY_W
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [KeyBits-1:0] key,
    input  logic               restart,
    output logic               Speaker
);
    logic [TONE_W-1:0] count;
    logic [TONE_W-1:0] half;
    logic              level;

    assign half = TONE_W'(HALF_PERIOD[key]);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
            level <= 1'b0;
        end else if (restart || key == '0) begin
            count <= '0;
            level <= 1'b0;
        end else if (count == half - 1'b1) begin
            count <= '0;
            level <= ~level;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Masking keeps the output silent in the cycle right after a note ends.
    assign Speaker = level & ~restart;
endmodule

// File: rtl/music_player.sv
// music_player: walks the score RAM, holds each note for its duration and drives the speaker.
module music_player import music_pkg::*; #(
    parameter int DataLength  = KEY_W,
    parameter int AddressBits = 5,
    parameter int ScoreLength = 3,
    parameter int BeatCycles  = 25_000_000
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Play,
    input  logic                   Loop,
    output logic                   ReadOrWrite,
    output logic [AddressBits-1:0] Address,
    input  logic [DataLength-1:0]  KeyIn,
    input  logic [DataLength-1:0]  TimeIn,
    output logic                   Speaker,
    output logic [DataLength-1:0]  CurrentKey,
    output logic                   Busy,
    output logic                   Done
);
    localparam int BEAT_W = $clog2((2**DataLength - 1) * BeatCycles + 1);
    localparam logic [AddressBits-1:0] LAST = AddressBits'(ScoreLength - 1);

    logic [1:0]            state;
    logic [DataLength-1:0] note_time;
    logic [BEAT_W-1:0]     beat;
    logic                  hold_last;
    logic                  finish;

    assign ReadOrWrite = 1'b1;
    assign Busy        = state != IDLE;
    assign hold_last   = beat == BEAT_W'(note_time * BeatCycles - 1);
    // A zero duration marks the end of the score, as does running past the last entry.
    assign finish      = (state == CAPTURE && TimeIn == '0) ||
                         (state == HOLD && hold_last && Address >= LAST);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            Address    <= '0;
            CurrentKey <= '0;
            note_time  <= '0;
            beat       <= '0;
            Done       <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Busy && !Play) begin
                state      <= IDLE;
                Address    <= '0;
                CurrentKey <= '0;
            end else if (finish) begin
                state      <= Loop ? FETCH : IDLE;
                Address    <= '0;
                CurrentKey <= Loop ? CurrentKey : '0;
                Done       <= !Loop;
            end else begin
                case (state)
                    IDLE:    state <= Play ? FETCH : IDLE;
                    FETCH:   state <= CAPTURE;
                    CAPTURE: begin
                        state      <= HOLD;
                        CurrentKey <= KeyIn;
                        note_time  <= TimeIn;
                        beat       <= '0;
                    end
                    HOLD: begin
                        state   <= hold_last ? FETCH : HOLD;
                        Address <= hold_last ? Address + 1'b1 : Address;
                        beat    <= beat + 1'b1;
                    end
                endcase
            end
        end
    end

    tone_divider #(.KeyBits(DataLength)) u_tone (
        .Clock   (Clock),
        .Reset   (Reset),
        .key     (CurrentKey),
        .restart (state != HOLD),
        .Speaker (Speaker)
    );
endmodule

// File: tb/tb_music_player.sv
// tb_music_player: randomized and directed songs checked cycle by cycle against a score-level model.
module tb_music_player;
    import music_pkg::*;

    localparam int BC = 4;
    localparam int SL = 3;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Play  = 1'b0;
    logic       Loop  = 1'b0;
    logic       ReadOrWrite, Speaker, Busy, Done;
    logic [4:0] Address;
    logic [3:0] KeyIn = '0;
    logic [3:0] TimeIn = '0;
    logic [3:0] CurrentKey;

    int sc_key [32];
    int sc_time [32];

    typedef struct {int busy, addr, key, spk, done;} cyc_t;
    cyc_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    music_player #(.DataLength(4), .AddressBits(5), .ScoreLength(SL), .BeatCycles(BC)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Play        (Play),
        .Loop        (Loop),
        .ReadOrWrite (ReadOrWrite),
        .Address     (Address),
        .KeyIn       (KeyIn),
        .TimeIn      (TimeIn),
        .Speaker     (Speaker),
        .CurrentKey  (CurrentKey),
        .Busy        (Busy),
        .Done        (Done)
    );

    always #5 Clock = ~Clock;

    // Score RAM with a registered read port.
    always @(posedge Clock) begin
        KeyIn  <= 4'(sc_key[Address]);
        TimeIn <= 4'(sc_time[Address]);
    end

    task automatic chk(input string tag, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Expected per-cycle trace with Play held high, starting at the first FETCH cycle.
    function automatic void gen(input int len, input bit loop);
        int a = 0;
        exp_q.delete();
        while (exp_q.size() < len) begin
            int k = sc_key[a];
            int t = sc_time[a];
            exp_q.push_back('{1, a, -1, 0, 0});
            exp_q.push_back('{1, a, -1, 0, 0});
            for (int j = 1; j <= t * BC; j++)
                exp_q.push_back('{1, a, k, (k != 0) ? ((j - 1) / HALF_PERIOD[k]) % 2 : 0, 0});
            if (t == 0 || a == SL - 1) begin
                a = 0;
                if (!loop) exp_q.push_back('{0, 0, 0, 0, 1});
            end else begin
                a++;
            end
        end
    endfunction

    task automatic check_cycle(input int i);
        cyc_t e = exp_q[i];
        chk($sformatf("c%0d busy", i), Busy, e.busy);
        chk($sformatf("c%0d addr", i), Address, e.addr);
        chk($sformatf("c%0d spk", i), Speaker, e.spk);
        chk($sformatf("c%0d done", i), Done, e.done);
        if (e.key >= 0) chk($sformatf("c%0d key", i), CurrentKey, e.key);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " busy"}, Busy, 0);
        chk({tag, " addr"}, Address, 0);
        chk({tag, " key"}, CurrentKey, 0);
        chk({tag, " spk"}, Speaker, 0);
        chk({tag, " done"}, Done, 0);
        chk({tag, " rw"}, ReadOrWrite, 1);
    endtask

    task automatic load(input int k0, input int t0, input int k1, input int t1, input int k2, input int t2);
        sc_key[0] = k0; sc_time[0] = t0;
        sc_key[1] = k1; sc_time[1] = t1;
        sc_key[2] = k2; sc_time[2] = t2;
    endtask

    // Play a song, drop Play after cycle d (optionally pulsing Reset there instead) and check idle.
    task automatic run(input int len, input int d, input bit loop, input bit rst_mid);
        Loop = loop;
        gen(len, loop);
        @(negedge Clock);
        Play = 1'b1;
        for (int i = 0; i <= d; i++) begin
            @(negedge Clock);
            check_cycle(i);
        end
        if (rst_mid) begin
            #1 Reset = 1'b1;
            #1 check_idle("async_rst");
            #1 Reset = 1'b0;
            for (int i = 0; i < len; i++) begin
                @(negedge Clock);
                check_cycle(i);
            end
        end
        Play = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            check_idle($sformatf("stop%0d", i));
        end
    endtask

    initial begin
        foreach (sc_key[i]) begin
            sc_key[i]  = 0;
            sc_time[i] = 0;
        end
        #1 Reset = 1'b1;
        #10 check_idle("reset");
        Reset = 1'b0;

        load(1, 1, 2, 2, 0, 1);
        run(25, 24, 1'b0, 1'b0);
        run(60, 59, 1'b1, 1'b0);
        run(25, 10, 1'b0, 1'b0);
        run(30, 3, 1'b0, 1'b1);

        load(3, 1, 5, 0, 1, 1);
        run(9, 8, 1'b0, 1'b0);

        load(1, 10, 0, 2, 15, 1);
        run(59, 58, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int len = $urandom_range(10, 70);
            for (int a = 0; a < SL; a++) begin
                sc_key[a]  = $urandom_range(0, 15);
                sc_time[a] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3);
            end
            run(len, $urandom_range(0, len - 1), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
